// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/port encodings and default sizes for the memory arbiter.
package mem_arb_pkg;
  typedef enum logic {ARB, LOCKED} state_e;
  typedef enum logic [1:0] {PORT_D, PORT_I, PORT_X} port_e;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;
  localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating count of consecutive cycles the loader port was refused.
module arb_starve_counter #(
  parameter int MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc_i,
  output logic sat_o
);
  localparam int W = $clog2(MAX + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign sat_o = cnt_q == W'(MAX);
  // Any cycle without a refused request restarts the count.
  assign cnt_d = !inc_i ? '0 : sat_o ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clock)
    cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: three-port (data, fetch, loader) arbiter onto one synchronous single-port RAM,
// with loader starvation override and a loader burst lock.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  input  logic          x_req,
  input  logic          x_we,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  input  logic          x_lock,
  output logic          x_gnt,
  output logic          d_rvalid,
  output logic          i_rvalid,
  output logic          x_rvalid,
  output logic [DW-1:0] rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          cpu_stall
);
  state_e state_q, state_d;
  port_e  pend_port_q, pend_port_d;
  logic   pend_vld_q, pend_vld_d;
  logic   locked, sat;
  assign locked = state_q == LOCKED;
  // Loader wins when locked, starved, or uncontested; grants are suppressed while in reset.
  assign x_gnt = !reset && x_req && (locked || sat || !(d_req || i_req));
  assign d_gnt = !reset && !locked && d_req && !x_gnt;
  assign i_gnt = !reset && !locked && i_req && !d_req && !x_gnt;
  assign m_en    = d_gnt || i_gnt || x_gnt;
  assign m_we    = d_gnt ? d_we : x_gnt ? x_we : 1'b0;
  assign m_addr  = d_gnt ? d_addr : i_gnt ? i_addr : x_addr;
  assign m_wdata = d_gnt ? d_wdata : x_wdata;
  assign cpu_stall = !reset && ((d_req && !d_gnt) || (i_req && !i_gnt));
  assign d_rvalid = !reset && pend_vld_q && pend_port_q == PORT_D;
  assign i_rvalid = !reset && pend_vld_q && pend_port_q == PORT_I;
  assign x_rvalid = !reset && pend_vld_q && pend_port_q == PORT_X;
  assign rdata = (d_rvalid || i_rvalid || x_rvalid) ? m_rdata : '0;
  always_comb begin
    state_d = locked ? (x_lock ? LOCKED : ARB) : ((x_gnt && x_lock) ? LOCKED : ARB);
    pend_vld_d = m_en && !m_we;
    pend_port_d = d_gnt ? PORT_D : i_gnt ? PORT_I : PORT_X;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB;
      pend_vld_q <= 1'b0;
      pend_port_q <= PORT_D;
    end else begin
      state_q <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_port_q <= pend_port_d;
    end
  end
  arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clock(clock),
    .reset(reset),
    .inc_i(x_req && !x_gnt),
    .sat_o(sat)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario tests for mem_arbiter against a behavioural synchronous RAM.
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  logic clock = 1'b0;
  logic reset;
  logic d_req, d_we, i_req, x_req, x_we, x_lock;
  logic [9:0] d_addr, i_addr, x_addr, m_addr;
  logic [31:0] d_wdata, x_wdata, rdata, m_wdata, m_rdata;
  logic d_gnt, i_gnt, x_gnt, d_rvalid, i_rvalid, x_rvalid, m_en, m_we, cpu_stall;
  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always @(posedge clock)
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else m_rdata <= mem[m_addr];
    end

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata), .x_lock(x_lock), .x_gnt(x_gnt),
    .d_rvalid(d_rvalid), .i_rvalid(i_rvalid), .x_rvalid(x_rvalid), .rdata(rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .cpu_stall(cpu_stall)
  );

  task automatic idle();
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    i_req = 0; i_addr = '0;
    x_req = 0; x_we = 0; x_addr = '0; x_wdata = '0; x_lock = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle();
    repeat (2) @(posedge clock);
    @(negedge clock);
    d_req = 1; d_addr = 10'd4; i_req = 1; x_req = 1;
    #1;
    checks++;
    if ({d_gnt, i_gnt, x_gnt, m_en, m_we, cpu_stall} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000", {d_gnt, i_gnt, x_gnt, m_en, m_we, cpu_stall});
    end
    checks++;
    if ({d_rvalid, i_rvalid, x_rvalid} !== 3'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rvalid got %b rdata %h want 000 rdata 0", {d_rvalid, i_rvalid, x_rvalid}, rdata);
    end
    @(negedge clock);
    reset = 0; idle();
  endtask

  task automatic test_priority();
    @(negedge clock);
    idle(); d_req = 1; d_addr = 10'd5; i_req = 1; i_addr = 10'd6;
    #1;
    checks++;
    if ({d_gnt, i_gnt, x_gnt, cpu_stall, m_en, m_we} !== 6'b100110 || m_addr !== 10'd5) begin
      errors++; $display("FAIL prio_grant got d/i/x/stall/en/we=%b addr=%0d want 100110 addr=5", {d_gnt, i_gnt, x_gnt, cpu_stall, m_en, m_we}, m_addr);
    end
    @(negedge clock);
    idle();
    #1;
    checks++;
    if ({d_rvalid, i_rvalid, x_rvalid} !== 3'b100 || rdata !== 32'h1000_0005) begin
      errors++; $display("FAIL prio_rvalid got %b rdata=%h want 100 rdata=10000005", {d_rvalid, i_rvalid, x_rvalid}, rdata);
    end
  endtask

  task automatic test_starve();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      idle(); i_req = 1; i_addr = 10'd1; x_req = 1; x_addr = 10'd2;
      #1;
      checks++;
      if (x_gnt !== (c == 5) || i_gnt !== (c != 5) || cpu_stall !== (c == 5)) begin
        errors++; $display("FAIL starve_c%0d got x=%b i=%b stall=%b want x=%b", c, x_gnt, i_gnt, cpu_stall, c == 5);
      end
      if (c == 6) begin
        checks++;
        if (x_rvalid !== 1'b1 || i_rvalid !== 1'b0 || rdata !== 32'h1000_0002) begin
          errors++; $display("FAIL starve_xrvalid got x=%b i=%b rdata=%h want 1 0 10000002", x_rvalid, i_rvalid, rdata);
        end
        checks++;
        if (dut.u_starve.cnt_q !== 3'd0) begin
          errors++; $display("FAIL starve_cnt got %0d want 0", dut.u_starve.cnt_q);
        end
      end
    end
    @(negedge clock);
    idle();
  endtask

  task automatic test_lock();
    @(negedge clock);
    idle(); x_req = 1; x_we = 1; x_lock = 1; x_addr = 10'd0; x_wdata = 32'hC0DE_0000;
    #1;
    checks++;
    if (x_gnt !== 1'b1 || m_we !== 1'b1 || m_wdata !== 32'hC0DE_0000) begin
      errors++; $display("FAIL lock_enter got x=%b we=%b wdata=%h want 1 1 c0de0000", x_gnt, m_we, m_wdata);
    end
    @(negedge clock);
    idle(); x_lock = 1; d_req = 1; d_addr = 10'd7;
    #1;
    checks++;
    if (m_en !== 1'b0 || m_we !== 1'b0 || {d_gnt, i_gnt, x_gnt} !== 3'b0 || cpu_stall !== 1'b1) begin
      errors++; $display("FAIL lock_idle got en=%b we=%b gnt=%b stall=%b want 0 0 000 1", m_en, m_we, {d_gnt, i_gnt, x_gnt}, cpu_stall);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      idle(); d_req = 1; d_addr = 10'd7;
      x_req = 1; x_we = 1; x_lock = (k < 3); x_addr = 10'(k); x_wdata = 32'hC0DE_0000 + k;
      #1;
      checks++;
      if (d_gnt !== 1'b0 || x_gnt !== 1'b1 || cpu_stall !== 1'b1 || m_addr !== 10'(k)) begin
        errors++; $display("FAIL lock_k%0d got d=%b x=%b stall=%b addr=%0d want 0 1 1 %0d", k, d_gnt, x_gnt, cpu_stall, m_addr, k);
      end
    end
    @(negedge clock);
    idle(); d_req = 1; d_addr = 10'd2;
    #1;
    checks++;
    if (d_gnt !== 1'b1 || cpu_stall !== 1'b0 || m_addr !== 10'd2) begin
      errors++; $display("FAIL lock_exit got d=%b stall=%b addr=%0d want 1 0 2", d_gnt, cpu_stall, m_addr);
    end
    @(negedge clock);
    idle();
    #1;
    checks++;
    if (d_rvalid !== 1'b1 || rdata !== 32'hC0DE_0002) begin
      errors++; $display("FAIL lock_readback got rvalid=%b rdata=%h want 1 c0de0002", d_rvalid, rdata);
    end
  endtask

  task automatic test_write_read();
    @(negedge clock);
    idle(); d_req = 1; d_we = 1; d_addr = 10'd9; d_wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (d_gnt !== 1'b1 || m_en !== 1'b1 || m_we !== 1'b1 || m_addr !== 10'd9 || m_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_cycle got gnt=%b en=%b we=%b addr=%0d wdata=%h", d_gnt, m_en, m_we, m_addr, m_wdata);
    end
    @(negedge clock);
    idle(); i_req = 1; i_addr = 10'd9;
    #1;
    checks++;
    if ({d_rvalid, i_rvalid, x_rvalid} !== 3'b0 || i_gnt !== 1'b1 || m_we !== 1'b0) begin
      errors++; $display("FAIL wr_no_rvalid got rv=%b i_gnt=%b we=%b want 000 1 0", {d_rvalid, i_rvalid, x_rvalid}, i_gnt, m_we);
    end
    @(negedge clock);
    idle();
    #1;
    checks++;
    if (i_rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_readback got rvalid=%b rdata=%h want 1 deadbeef", i_rvalid, rdata);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c <= 3; c++) begin
      @(negedge clock);
      idle();
      if (c < 3) begin i_req = 1; i_addr = 10'd10 + 10'(c); end
      #1;
      checks++;
      if (i_gnt !== (c < 3) || i_rvalid !== (c > 0) || (c > 0 && rdata !== 32'h1000_0009 + c)) begin
        errors++; $display("FAIL b2b_c%0d got gnt=%b rvalid=%b rdata=%h", c, i_gnt, i_rvalid, rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    idle(); x_req = 1; x_lock = 1; x_addr = 10'd20;
    @(negedge clock);
    idle(); x_lock = 1; i_req = 1; i_addr = 10'd3;
    #1;
    checks++;
    if (i_gnt !== 1'b0 || x_rvalid !== 1'b1 || rdata !== 32'h1000_0014) begin
      errors++; $display("FAIL rst_locked got i_gnt=%b x_rvalid=%b rdata=%h want 0 1 10000014", i_gnt, x_rvalid, rdata);
    end
    @(negedge clock);
    idle(); i_req = 1; i_addr = 10'd3; reset = 1;
    #1;
    checks++;
    if (i_gnt !== 1'b0 || m_en !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL rst_mid_gnt got gnt=%b en=%b stall=%b want 0 0 0", i_gnt, m_en, cpu_stall);
    end
    @(negedge clock);
    idle(); reset = 0;
    #1;
    checks++;
    if ({d_gnt, i_gnt, x_gnt, d_rvalid, i_rvalid, x_rvalid, m_en, m_we, cpu_stall} !== 9'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL rst_after got %b rdata=%h want all 0", {d_gnt, i_gnt, x_gnt, d_rvalid, i_rvalid, x_rvalid, m_en, m_we, cpu_stall}, rdata);
    end
    checks++;
    if (dut.state_q !== ARB || dut.u_starve.cnt_q !== 3'd0) begin
      errors++; $display("FAIL rst_state got state=%0d cnt=%0d want 0 0", dut.state_q, dut.u_starve.cnt_q);
    end
    @(negedge clock);
    idle(); d_req = 1; d_addr = 10'd1;
    #1;
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL rst_arb_dgnt got %b want 1", d_gnt);
    end
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 32'h1000_0000 + k;
    test_reset();
    test_priority();
    test_starve();
    test_lock();
    test_write_read();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 10: memory word-address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter STARVE_MAX, default 4: number of denied cycles before the loader port is forced to win.
REQ-004 clock  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 d_req, d_we, d_addr[AW], d_wdata[DW]  input  CPU data-port request, write enable, address and write data.
REQ-007 d_gnt  output  1  data-port request accepted this cycle.
REQ-008 i_req, i_addr[AW]  input  CPU instruction-fetch read request and address.
REQ-009 i_gnt  output  1  fetch request accepted this cycle.
REQ-010 x_req, x_we, x_addr[AW], x_wdata[DW], x_lock  input  loader/debug request, write enable, address, write data and burst-lock.
REQ-011 x_gnt  output  1  loader request accepted this cycle.
REQ-012 d_rvalid, i_rvalid, x_rvalid  output  1 each  read data on rdata belongs to that port.
REQ-013 rdata  output  DW  shared read-return bus, driven from m_rdata.
REQ-014 m_en, m_we, m_addr[AW], m_wdata[DW]  output  single-port synchronous RAM controls.
REQ-015 m_rdata  input  DW  RAM read data, valid one cycle after m_en with m_we=0.
REQ-016 cpu_stall  output  1  CPU pipeline must hold this cycle.

Function
REQ-017 Arbitration SHALL be combinational in the request cycle; at most one of d_gnt/i_gnt/x_gnt SHALL be high per cycle.
REQ-018 A grant SHALL only be issued to a port whose req is high.
REQ-019 In state ARB, priority SHALL be: x if starve_cnt==STARVE_MAX; else d > i > x.
REQ-020 In state LOCKED, only x SHALL be granted; d and i SHALL be denied.
REQ-021 The granted port's we/addr/wdata SHALL drive m_we/m_addr/m_wdata, and m_en SHALL equal OR of grants; with no grant m_en=0 and m_we=0.
REQ-022 For each granted read, exactly one rvalid of that port SHALL assert in the next cycle with rdata=m_rdata; writes SHALL produce no rvalid.
REQ-023 Back-to-back reads SHALL be accepted every cycle (throughput 1/cycle, latency 1).
REQ-024 starve_cnt SHALL increment when x_req && !x_gnt, saturate at STARVE_MAX, and clear on x_gnt or !x_req.
REQ-025 ARB->LOCKED SHALL occur when x_gnt && x_lock; LOCKED->ARB SHALL occur on the cycle after x_lock=0, and that cycle SHALL use normal ARB arbitration.
REQ-026 In LOCKED with x_req=0, no grant SHALL be issued and the memory SHALL idle.
REQ-027 cpu_stall SHALL equal (d_req && !d_gnt) || (i_req && !i_gnt).
REQ-028 Address and data SHALL pass unmodified; no wrap or arithmetic on addresses.

Reset
REQ-029 During reset, all grants, rvalids, m_en, m_we and cpu_stall SHALL be 0; rdata SHALL be 0.
REQ-030 Reset SHALL return the state to ARB and clear starve_cnt.
REQ-031 A read granted in the cycle reset asserts SHALL NOT produce an rvalid after reset.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the state enum (ARB, LOCKED), the port-ID encoding (D, I, X) and the default AW/DW/STARVE_MAX constants.
REQ-033 The saturating starvation counter SHALL be the sub-module arb_starve_counter; the rest SHALL be flat.

Verification
REQ-034 d_req read addr 5 and i_req addr 6 in the same cycle -> d_gnt=1, i_gnt=0, cpu_stall=1, m_addr=5; next cycle d_rvalid=1, rdata=mem[5].
REQ-035 i_req continuous and x_req continuous, d idle -> x_gnt=0 for 4 cycles, then x_gnt=1 in cycle 5, starve_cnt returns to 0.
REQ-036 x write with x_lock=1 to addr 0..3 over 4 cycles while d_req=1 -> d_gnt=0 throughout, cpu_stall=1; x_lock=0 -> next cycle d_gnt=1.
REQ-037 d write addr 9 data 0xDEADBEEF, then i read addr 9 -> m_we=1 on the first cycle, no rvalid for it; i_rvalid=1 with rdata=0xDEADBEEF two cycles after the write.
REQ-038 i read granted, reset asserted same cycle -> i_rvalid=0 next cycle; after reset release state=ARB, all outputs 0 with no requests.
